// File: rtl/tdm_demux4.sv
// Four-slot serial TDM demultiplexer: hunts for fsync, then assembles one W-bit
// word per slot MSB-first and presents all four words together once a full set is in.
module tdm_demux4 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din,
  input  logic         din_valid,
  input  logic         fsync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         out_valid,
  output logic         locked,
  output logic         sync_err
);

  localparam int unsigned BW    = $clog2(W);
  localparam int unsigned NSLOT = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                       state, state_nxt;
  logic [1:0]                   slot, slot_nxt;
  logic [BW-1:0]                bcnt, bcnt_nxt;
  logic [NSLOT-1:0][W-1:0]      sr, sr_nxt;
  logic [NSLOT-1:0][W-1:0]      ch, ch_nxt;
  logic                         ov_nxt;
  logic                         se_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: lock on fsync, drop back to HUNT when a slot-0 beat lacks fsync
  always_comb begin
    state_nxt = state;
    if (din_valid) begin
      unique case (state)
        HUNT:    if (fsync) state_nxt = LOCKED;
        LOCKED:  if (!fsync && (slot == 2'd0)) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Datapath and output next values; idle cycles hold everything and clear pulses
  always_comb begin
    slot_nxt = slot;
    bcnt_nxt = bcnt;
    sr_nxt   = sr;
    ch_nxt   = ch;
    ov_nxt   = 1'b0;
    se_nxt   = 1'b0;
    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (fsync) begin
            sr_nxt[0] = {sr[0][W-2:0], din};
            slot_nxt  = 2'd1;
            bcnt_nxt  = '0;
          end
        end
        LOCKED: begin
          if (fsync && (slot != 2'd0)) begin
            // Early frame marker: restart the word set with this beat as slot 0
            se_nxt    = 1'b1;
            sr_nxt    = '0;
            sr_nxt[0] = W'(din);
            slot_nxt  = 2'd1;
            bcnt_nxt  = '0;
          end else if (!fsync && (slot == 2'd0)) begin
            se_nxt   = 1'b1;
            slot_nxt = 2'd0;
            bcnt_nxt = '0;
          end else begin
            sr_nxt[slot] = {sr[slot][W-2:0], din};
            slot_nxt     = slot + 2'd1;
            if (slot == 2'd3) begin
              if (bcnt == BW'(W - 1)) begin
                bcnt_nxt = '0;
                ov_nxt   = 1'b1;
                ch_nxt   = sr_nxt;
              end else begin
                bcnt_nxt = bcnt + BW'(1);
              end
            end
          end
        end
        default: begin
          slot_nxt = 2'd0;
          bcnt_nxt = '0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= 2'd0;
      bcnt      <= '0;
      sr        <= '0;
      ch        <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      slot      <= slot_nxt;
      bcnt      <= bcnt_nxt;
      sr        <= sr_nxt;
      ch        <= ch_nxt;
      out_valid <= ov_nxt;
      sync_err  <= se_nxt;
      locked    <= (state_nxt == LOCKED);
    end
  end

  assign ch0 = ch[0];
  assign ch1 = ch[1];
  assign ch2 = ch[2];
  assign ch3 = ch[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed scenarios plus random traffic, all compared
// against a queue-based frame model.
module tb_tdm_demux4;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         fsync = 1'b0;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         out_valid, locked, sync_err;

  tdm_demux4 #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .fsync     (fsync),
    .ch0       (ch0),
    .ch1       (ch1),
    .ch2       (ch2),
    .ch3       (ch3),
    .out_valid (out_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_se   = 0;
  int n_ov   = 0;

  // Reference model: bits collected since the last frame marker, in arrival order
  bit           m_locked;
  bit           q[$];
  logic [W-1:0] m_ch [4];
  bit           m_ov, m_se;

  logic [W-1:0] words [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_locked = 0;
    q.delete();
    for (int s = 0; s < 4; s++) m_ch[s] = '0;
    m_ov = 0;
    m_se = 0;
  endtask

  task automatic model_beat(input bit d, input bit f);
    int pos;
    m_ov = 0;
    m_se = 0;
    if (!m_locked) begin
      if (f) begin
        m_locked = 1;
        q.delete();
        q.push_back(d);
      end
    end else begin
      pos = q.size();
      if (f && (pos % 4 != 0)) begin
        m_se = 1;
        q.delete();
        q.push_back(d);
      end else if (!f && (pos % 4 == 0)) begin
        m_se = 1;
        m_locked = 0;
        q.delete();
      end else begin
        q.push_back(d);
        if (q.size() == 4 * W) begin
          for (int s = 0; s < 4; s++) begin
            logic [W-1:0] v;
            v = '0;
            for (int k = 0; k < W; k++) v = {v[W-2:0], q[4*k+s]};
            m_ch[s] = v;
          end
          m_ov = 1;
          q.delete();
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    check({tag, ".sync_err"},  32'(sync_err),  32'(m_se));
    check({tag, ".locked"},    32'(locked),    32'(m_locked));
    check({tag, ".ch0"}, 32'(ch0), 32'(m_ch[0]));
    check({tag, ".ch1"}, 32'(ch1), 32'(m_ch[1]));
    check({tag, ".ch2"}, 32'(ch2), 32'(m_ch[2]));
    check({tag, ".ch3"}, 32'(ch3), 32'(m_ch[3]));
  endtask

  // One clock: drive, clock, sample 1ns after the edge, update model, compare
  task automatic step(input string tag, input bit v, input bit d, input bit f);
    din_valid = v;
    din       = d;
    fsync     = f;
    @(posedge clk);
    #1;
    if (v) model_beat(d, f);
    else begin
      m_ov = 0;
      m_se = 0;
    end
    if (sync_err) n_se++;
    if (out_valid) n_ov++;
    compare_all(tag);
  endtask

  // First nb beats of the A5/3C/FF/00 stream; gap inserts an idle cycle before each beat after the first
  task automatic send_set(input string tag, input bit gap, input int nb);
    for (int b = 0; b < nb; b++) begin
      int k, s;
      logic [W-1:0] wd;
      k = b / 4;
      s = b % 4;
      wd = words[s];
      if (gap && b != 0) step(tag, 1'b0, 1'b0, 1'b0);
      step(tag, 1'b1, wd[W-1-k], (s == 0));
    end
    if (nb == 4 * W) begin
      check({tag, ".final_ov"}, 32'(out_valid), 32'd1);
      check({tag, ".a5"}, 32'(ch0), 32'h a5);
      check({tag, ".3c"}, 32'(ch1), 32'h 3c);
      check({tag, ".ff"}, 32'(ch2), 32'h ff);
      check({tag, ".00"}, 32'(ch3), 32'h 00);
    end
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_ch0"}, 32'(ch0), 32'd0);
    check({tag, ".rst_ch1"}, 32'(ch1), 32'd0);
    check({tag, ".rst_ch2"}, 32'(ch2), 32'd0);
    check({tag, ".rst_ch3"}, 32'(ch3), 32'd0);
    check({tag, ".rst_ov"},  32'(out_valid), 32'd0);
    check({tag, ".rst_lock"},32'(locked), 32'd0);
    check({tag, ".rst_se"},  32'(sync_err), 32'd0);
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int se0, ov0, pos;
    bit v, f;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00;
    model_reset();
    #2;
    async_reset("por");

    // Nominal
    send_set("nominal", 1'b0, 32);

    // Gapped
    send_set("gapped", 1'b1, 32);

    // Hunt: reset first, then 5 unframed beats
    async_reset("hunt_rst");
    se0 = n_se;
    for (int i = 0; i < 5; i++) begin
      step("hunt", 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check("hunt.unlocked", 32'(locked), 32'd0);
    end
    send_set("hunt", 1'b0, 32);
    check("hunt.no_se", 32'(n_se - se0), 32'd0);

    // Misalignment: fsync lands at slot 2 of frame 3
    se0 = n_se;
    ov0 = n_ov;
    send_set("misalign", 1'b0, 14);
    send_set("misalign", 1'b0, 32);
    check("misalign.se_once", 32'(n_se - se0), 32'd1);
    check("misalign.ov_once", 32'(n_ov - ov0), 32'd1);

    // Missing sync on a slot-0 beat
    send_set("nosync", 1'b0, 4);
    step("nosync", 1'b1, 1'b1, 1'b0);
    check("nosync.se", 32'(sync_err), 32'd1);
    check("nosync.unlock", 32'(locked), 32'd0);
    send_set("nosync", 1'b0, 32);

    // Reset mid-word
    send_set("midrst", 1'b0, 20);
    ov0 = n_ov;
    async_reset("midrst");
    send_set("midrst", 1'b0, 32);
    check("midrst.ov_once", 32'(n_ov - ov0), 32'd1);

    // Random traffic, mostly well framed
    pos = 0;
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = (pos % 4 == 0) ^ ($urandom_range(0, 59) == 0);
      step("rand", v, 1'($urandom_range(0, 1)), f);
      if (v) pos++;
      check("rand.excl", 32'(out_valid & sync_err), 32'd0);
    end
    check("rand.saw_ov", 32'(n_ov > 8), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
